// File: rtl/riscv_pkg.sv
// Shared RV64IM decode definitions: opcodes, ALU operation codes, immediate formats
// and the registered control bundle handed to execute.
package riscv_pkg;

    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcOpImm32 = 7'b0011011;
    localparam logic [6:0] OpcOp32    = 7'b0111011;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcJalr    = 7'b1100111;

    typedef enum logic [5:0] {
        AluAdd    = 6'd0,
        AluSub    = 6'd1,
        AluSll    = 6'd2,
        AluSlt    = 6'd3,
        AluSltu   = 6'd4,
        AluXor    = 6'd5,
        AluSrl    = 6'd6,
        AluSra    = 6'd7,
        AluOr     = 6'd8,
        AluAnd    = 6'd9,
        AluAddw   = 6'd10,
        AluSubw   = 6'd11,
        AluSllw   = 6'd12,
        AluSrlw   = 6'd13,
        AluSraw   = 6'd14,
        AluMul    = 6'd15,
        AluMulh   = 6'd16,
        AluMulhsu = 6'd17,
        AluMulhu  = 6'd18,
        AluDiv    = 6'd19,
        AluDivu   = 6'd20,
        AluRem    = 6'd21,
        AluRemu   = 6'd22,
        AluMulw   = 6'd23,
        AluDivw   = 6'd24,
        AluDivuw  = 6'd25,
        AluRemw   = 6'd26,
        AluRemuw  = 6'd27
    } alu_op_e;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ,
        ImmShamt,
        ImmShamtW
    } imm_fmt_e;

    typedef struct packed {
        alu_op_e    alu_control;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [2:0] branch_type;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_or_reg;
        logic [2:0] mem_size;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_regfile.sv
// Integer register file: two async read ports, one write port, x0 reads as zero.
// Same-cycle write-to-read forwarding when DECODE_WB_BYPASS_EN is defined.
module decode_stage_regfile #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned NumRegs   = 32,
    parameter int unsigned AddrWidth = $clog2(NumRegs)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [AddrWidth-1:0] raddr1_i,
    input  logic [AddrWidth-1:0] raddr2_i,
    output logic [DataWidth-1:0] rdata1_o,
    output logic [DataWidth-1:0] rdata2_o
);

    logic [DataWidth-1:0] regs_q [NumRegs];
    logic [DataWidth-1:0] regs_d [NumRegs];

    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != '0)) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (raddr1_i != '0) begin
            rdata1_o = regs_q[raddr1_i];
`ifdef DECODE_WB_BYPASS_EN
            if (we_i && (waddr_i == raddr1_i)) begin
                rdata1_o = wdata_i;
            end
`endif
        end
        if (raddr2_i != '0) begin
            rdata2_o = regs_q[raddr2_i];
`ifdef DECODE_WB_BYPASS_EN
            if (we_i && (waddr_i == raddr2_i)) begin
                rdata2_o = wdata_i;
            end
`endif
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV64IM decode stage: decodes, reads operands, builds immediates and registers the
// bundle for execute. Optional same-cycle writeback bypass: DECODE_WB_BYPASS_EN.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned REG_ADDR_W     = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BUS_DATA_WIDTH-1:0] in_pc,
    input  logic [31:0]               in_ins,
    input  logic                      flush,
    input  logic                      wb_en,
    input  logic [REG_ADDR_W-1:0]     wb_rd,
    input  logic [BUS_DATA_WIDTH-1:0] wb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BUS_DATA_WIDTH-1:0] out_pc,
    output logic [BUS_DATA_WIDTH-1:0] out_read_data1,
    output logic [BUS_DATA_WIDTH-1:0] out_read_data2,
    output logic [BUS_DATA_WIDTH-1:0] out_imm,
    output logic [REG_ADDR_W-1:0]     out_dest_reg,
    output logic [5:0]                out_alu_control,
    output logic                      out_alu_src,
    output logic                      out_branch,
    output logic                      out_jump,
    output logic [2:0]                out_branch_type,
    output logic                      out_mem_read,
    output logic                      out_mem_write,
    output logic                      out_reg_write,
    output logic                      out_mem_or_reg,
    output logic [2:0]                out_mem_size,
    output logic                      out_illegal
);

    localparam int unsigned W = BUS_DATA_WIDTH;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;

    assign opcode = in_ins[6:0];
    assign funct3 = in_ins[14:12];
    assign funct7 = in_ins[31:25];
    assign rs1    = REG_ADDR_W'(in_ins[19:15]);
    assign rs2    = REG_ADDR_W'(in_ins[24:20]);
    assign rd     = REG_ADDR_W'(in_ins[11:7]);

    ctrl_t    dec_ctrl;
    imm_fmt_e dec_fmt;
    logic     use_rs1, use_rs2, bad;

    always_comb begin
        dec_ctrl = '0;
        dec_fmt  = ImmNone;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        bad      = 1'b0;
        case (opcode)
            OpcOpImm: begin
                dec_fmt = ImmI;
                use_rs1 = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                case (funct3)
                    3'b000: dec_ctrl.alu_control = AluAdd;
                    3'b010: dec_ctrl.alu_control = AluSlt;
                    3'b011: dec_ctrl.alu_control = AluSltu;
                    3'b100: dec_ctrl.alu_control = AluXor;
                    3'b110: dec_ctrl.alu_control = AluOr;
                    3'b111: dec_ctrl.alu_control = AluAnd;
                    3'b001: begin
                        dec_fmt = ImmShamt;
                        dec_ctrl.alu_control = AluSll;
                        bad = (in_ins[31:26] != 6'b000000);
                    end
                    default: begin
                        dec_fmt = ImmShamt;
                        if (in_ins[31:26] == 6'b000000)      dec_ctrl.alu_control = AluSrl;
                        else if (in_ins[31:26] == 6'b010000) dec_ctrl.alu_control = AluSra;
                        else                                 bad = 1'b1;
                    end
                endcase
            end
            OpcOpImm32: begin
                dec_fmt = ImmI;
                use_rs1 = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                case (funct3)
                    3'b000: dec_ctrl.alu_control = AluAddw;
                    3'b001: begin
                        dec_fmt = ImmShamtW;
                        dec_ctrl.alu_control = AluSllw;
                        bad = (funct7 != 7'b0000000);
                    end
                    3'b101: begin
                        dec_fmt = ImmShamtW;
                        if (funct7 == 7'b0000000)      dec_ctrl.alu_control = AluSrlw;
                        else if (funct7 == 7'b0100000) dec_ctrl.alu_control = AluSraw;
                        else                           bad = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OpcOp: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  dec_ctrl.alu_control = AluAdd;
                            3'b001:  dec_ctrl.alu_control = AluSll;
                            3'b010:  dec_ctrl.alu_control = AluSlt;
                            3'b011:  dec_ctrl.alu_control = AluSltu;
                            3'b100:  dec_ctrl.alu_control = AluXor;
                            3'b101:  dec_ctrl.alu_control = AluSrl;
                            3'b110:  dec_ctrl.alu_control = AluOr;
                            default: dec_ctrl.alu_control = AluAnd;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec_ctrl.alu_control = AluSub;
                        else if (funct3 == 3'b101) dec_ctrl.alu_control = AluSra;
                        else                       bad = 1'b1;
                    end
                    7'b0000001: begin
                        case (funct3)
                            3'b000:  dec_ctrl.alu_control = AluMul;
                            3'b001:  dec_ctrl.alu_control = AluMulh;
                            3'b010:  dec_ctrl.alu_control = AluMulhsu;
                            3'b011:  dec_ctrl.alu_control = AluMulhu;
                            3'b100:  dec_ctrl.alu_control = AluDiv;
                            3'b101:  dec_ctrl.alu_control = AluDivu;
                            3'b110:  dec_ctrl.alu_control = AluRem;
                            default: dec_ctrl.alu_control = AluRemu;
                        endcase
                    end
                    default: bad = 1'b1;
                endcase
            end
            OpcOp32: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec_ctrl.alu_control = AluAddw;
                    {7'b0000000, 3'b001}: dec_ctrl.alu_control = AluSllw;
                    {7'b0000000, 3'b101}: dec_ctrl.alu_control = AluSrlw;
                    {7'b0100000, 3'b000}: dec_ctrl.alu_control = AluSubw;
                    {7'b0100000, 3'b101}: dec_ctrl.alu_control = AluSraw;
                    {7'b0000001, 3'b000}: dec_ctrl.alu_control = AluMulw;
                    {7'b0000001, 3'b100}: dec_ctrl.alu_control = AluDivw;
                    {7'b0000001, 3'b101}: dec_ctrl.alu_control = AluDivuw;
                    {7'b0000001, 3'b110}: dec_ctrl.alu_control = AluRemw;
                    {7'b0000001, 3'b111}: dec_ctrl.alu_control = AluRemuw;
                    default:              bad = 1'b1;
                endcase
            end
            OpcLoad: begin
                dec_fmt = ImmI;
                use_rs1 = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_or_reg = 1'b1;
                dec_ctrl.mem_size   = funct3;
                bad = (funct3 == 3'b111);
            end
            OpcStore: begin
                dec_fmt = ImmS;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.mem_size  = funct3;
                bad = funct3[2];
            end
            OpcBranch: begin
                dec_fmt = ImmB;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_ctrl.alu_control = AluSub;
                dec_ctrl.branch      = 1'b1;
                dec_ctrl.branch_type = funct3;
                bad = (funct3[2:1] == 2'b01);
            end
            OpcLui, OpcAuipc: begin
                dec_fmt = ImmU;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            OpcJal: begin
                dec_fmt = ImmJ;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            OpcJalr: begin
                dec_fmt = ImmI;
                use_rs1 = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                bad = (funct3 != 3'b000);
            end
            default: bad = 1'b1;
        endcase
        // Illegal encodings carry no side effects and read no sources.
        if (bad) begin
            dec_ctrl         = '0;
            dec_ctrl.illegal = 1'b1;
            dec_fmt          = ImmNone;
            use_rs1          = 1'b0;
            use_rs2          = 1'b0;
        end
    end

    logic [W-1:0] dec_imm;

    always_comb begin
        case (dec_fmt)
            ImmI:      dec_imm = {{(W-12){in_ins[31]}}, in_ins[31:20]};
            ImmS:      dec_imm = {{(W-12){in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
            ImmB:      dec_imm = {{(W-13){in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25],
                                  in_ins[11:8], 1'b0};
            ImmU:      dec_imm = {{(W-32){in_ins[31]}}, in_ins[31:12], 12'b0};
            ImmJ:      dec_imm = {{(W-21){in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20],
                                  in_ins[30:21], 1'b0};
            ImmShamt:  dec_imm = {{(W-6){1'b0}}, in_ins[25:20]};
            ImmShamtW: dec_imm = {{(W-5){1'b0}}, in_ins[24:20]};
            default:   dec_imm = '0;
        endcase
    end

    logic [W-1:0] rf_rdata1, rf_rdata2;

    decode_stage_regfile #(
        .DataWidth (W),
        .NumRegs   (NUM_REGS),
        .AddrWidth (REG_ADDR_W)
    ) u_regfile (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .we_i     (wb_en),
        .waddr_i  (wb_rd),
        .wdata_i  (wb_data),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    logic                  valid_q, valid_d;
    logic [W-1:0]          pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic                  advance, hazard, load;

    // Load-use: the held load's destination feeds a source of the incoming instruction.
    assign hazard = valid_q & ctrl_q.mem_read & (dest_q != '0) &
                    ((use_rs1 & (dest_q == rs1)) | (use_rs2 & (dest_q == rs2)));
    assign advance  = !valid_q | out_ready;
    assign in_ready = reset_n & advance & !hazard & !flush;
    assign load     = in_valid & in_ready;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        dest_d  = dest_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (advance) begin
            valid_d = load;
            if (load) begin
                pc_d   = in_pc;
                rd1_d  = use_rs1 ? rf_rdata1 : '0;
                rd2_d  = use_rs2 ? rf_rdata2 : '0;
                imm_d  = dec_imm;
                dest_d = dec_ctrl.reg_write ? rd : '0;
                ctrl_d = dec_ctrl;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            dest_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            dest_q  <= dest_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_pc          = pc_q;
    assign out_read_data1  = rd1_q;
    assign out_read_data2  = rd2_q;
    assign out_imm         = imm_q;
    assign out_dest_reg    = dest_q;
    assign out_alu_control = ctrl_q.alu_control;
    assign out_alu_src     = ctrl_q.alu_src;
    assign out_branch      = ctrl_q.branch;
    assign out_jump        = ctrl_q.jump;
    assign out_branch_type = ctrl_q.branch_type;
    assign out_mem_read    = ctrl_q.mem_read;
    assign out_mem_write   = ctrl_q.mem_write;
    assign out_reg_write   = ctrl_q.reg_write;
    assign out_mem_or_reg  = ctrl_q.mem_or_reg;
    assign out_mem_size    = ctrl_q.mem_size;
    assign out_illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver pushes hand-computed bundles on issue,
// a monitor pops and compares every bundle execute accepts.
module tb_decode_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [63:0] in_pc = '0;
    logic [31:0] in_ins = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [63:0] out_pc, out_read_data1, out_read_data2, out_imm;
    logic [4:0]  out_dest_reg;
    logic [5:0]  out_alu_control;
    logic        out_alu_src, out_branch, out_jump;
    logic [2:0]  out_branch_type, out_mem_size;
    logic        out_mem_read, out_mem_write, out_reg_write, out_mem_or_reg, out_illegal;

    decode_stage dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_ins          (in_ins),
        .flush           (flush),
        .wb_en           (wb_en),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_read_data1  (out_read_data1),
        .out_read_data2  (out_read_data2),
        .out_imm         (out_imm),
        .out_dest_reg    (out_dest_reg),
        .out_alu_control (out_alu_control),
        .out_alu_src     (out_alu_src),
        .out_branch      (out_branch),
        .out_jump        (out_jump),
        .out_branch_type (out_branch_type),
        .out_mem_read    (out_mem_read),
        .out_mem_write   (out_mem_write),
        .out_reg_write   (out_reg_write),
        .out_mem_or_reg  (out_mem_or_reg),
        .out_mem_size    (out_mem_size),
        .out_illegal     (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc, rd1, rd2, imm;
        logic [4:0]  dest;
        logic [5:0]  alu;
        logic        alu_src, branch, jump;
        logic [2:0]  btype;
        logic        mem_read, mem_write, reg_write, mem_or_reg;
        logic [2:0]  msize;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] pc, input logic [63:0] rd1,
                                input logic [63:0] rd2, input logic [63:0] imm,
                                input logic [4:0] dest, input alu_op_e alu, input logic src);
        exp_t e;
        e = '0;
        e.pc = pc; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
        e.dest = dest; e.alu = alu; e.alu_src = src;
        e.reg_write = (dest != 5'd0);
        return e;
    endfunction

    // Monitor: a bundle transfers on every cycle with out_valid & out_ready and no flush.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready && !flush) begin
            exp_t g, e;
            g = {out_pc, out_read_data1, out_read_data2, out_imm, out_dest_reg, out_alu_control,
                 out_alu_src, out_branch, out_jump, out_branch_type, out_mem_read, out_mem_write,
                 out_reg_write, out_mem_or_reg, out_mem_size, out_illegal};
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_bundle: got pc=%h with no bundle expected", out_pc);
            end else begin
                e = sb.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL bundle pc=%h: got rd1=%h rd2=%h imm=%h dest=%0d alu=%0d ctl=%b, expected rd1=%h rd2=%h imm=%h dest=%0d alu=%0d ctl=%b",
                             e.pc, g.rd1, g.rd2, g.imm, g.dest, g.alu, g[17:0],
                             e.rd1, e.rd2, e.imm, e.dest, e.alu, e[17:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] r, input logic [63:0] d);
        wb_en = 1'b1; wb_rd = r; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [63:0] pc, input exp_t e,
                         input bit push, output int stalls);
        in_valid = 1'b1; in_ins = ins; in_pc = pc;
        stalls = 0;
        @(negedge clk);
        while (!in_ready && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no in_ready for ins %h, required acceptance", ins);
        end else if (push) begin
            sb.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        exp_t e, a_exp;
        int   st;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_imm", out_imm, 64'd0);
        check("rst_out_ctrl", {out_dest_reg, out_alu_control, out_reg_write, out_mem_read}, 64'd0);
        reset_n = 1'b1;
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);
        tick();

        wb(5'd1, 64'h100);
        wb(5'd2, 64'h22);
        wb(5'd6, 64'h66);
        wb(5'd7, 64'h1234);

        // addi x5,x0,-1
        issue(32'hFFF00293, 64'h1000, mk(64'h1000, 0, 0, '1, 5'd5, AluAdd, 1'b1), 1, st);
        // beq x7,x7,-8
        e = mk(64'h1004, 64'h1234, 64'h1234, 64'hFFFF_FFFF_FFFF_FFF8, 5'd0, AluSub, 1'b0);
        e.branch = 1'b1;
        issue(32'hFE738CE3, 64'h1004, e, 1, st);
        // sd x2,8(x1)
        e = mk(64'h1008, 64'h100, 64'h22, 64'd8, 5'd0, AluAdd, 1'b1);
        e.mem_write = 1'b1; e.msize = 3'd3;
        issue(32'h0020B423, 64'h1008, e, 1, st);
        // lui x15,0x80000
        issue(32'h800007B7, 64'h100C,
              mk(64'h100C, 0, 0, 64'hFFFF_FFFF_8000_0000, 5'd15, AluAdd, 1'b1), 1, st);
        // jal x1,+16
        e = mk(64'h1010, 0, 0, 64'd16, 5'd1, AluAdd, 1'b1);
        e.jump = 1'b1;
        issue(32'h010000EF, 64'h1010, e, 1, st);
        // sraiw x16,x1,3
        issue(32'h4030D81B, 64'h1014, mk(64'h1014, 64'h100, 0, 64'd3, 5'd16, AluSraw, 1'b1), 1, st);
        // mul x17,x1,x2
        issue(32'h022088B3, 64'h1018, mk(64'h1018, 64'h100, 64'h22, 0, 5'd17, AluMul, 1'b0), 1, st);
        // unknown opcode
        e = '0; e.pc = 64'h101C; e.illegal = 1'b1;
        issue(32'hFFFFFFFF, 64'h101C, e, 1, st);

        // Load-use: ld x6,0(x1) then add x8,x6,x2
        e = mk(64'h1020, 64'h100, 0, 0, 5'd6, AluAdd, 1'b1);
        e.mem_read = 1'b1; e.mem_or_reg = 1'b1; e.msize = 3'd3;
        issue(32'h0000B303, 64'h1020, e, 1, st);
        issue(32'h00230433, 64'h1024, mk(64'h1024, 64'h66, 64'h22, 0, 5'd8, AluAdd, 1'b0), 1, st);
        check("load_use_stall_cycles", 64'(st), 64'd1);
        repeat (2) tick();

        // Back-pressure: addi x9,x0,5 held three cycles while slti x10,x0,-1 waits
        out_ready = 1'b0;
        a_exp = mk(64'h2000, 0, 0, 64'd5, 5'd9, AluAdd, 1'b1);
        issue(32'h00500493, 64'h2000, a_exp, 1, st);
        in_valid = 1'b1; in_ins = 32'hFFF02513; in_pc = 64'h2004;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out_pc", out_pc, a_exp.pc);
            check("stall_out_imm_dest", {out_imm[58:0], out_dest_reg}, {a_exp.imm[58:0], a_exp.dest});
            tick();
        end
        out_ready = 1'b1;
        issue(32'hFFF02513, 64'h2004, mk(64'h2004, 0, 0, '1, 5'd10, AluSlt, 1'b1), 1, st);
        repeat (2) tick();

        // Flush a held addi x11,x0,1 and drop addi x12,x0,2 presented alongside
        out_ready = 1'b0;
        issue(32'h00100593, 64'h3000, a_exp, 0, st);
        flush = 1'b1; in_valid = 1'b1; in_ins = 32'h00200613; in_pc = 64'h3004;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (2) tick();

        // Writes to x0 are discarded
        wb(5'd0, 64'hDEAD);
        issue(32'h000000B3, 64'h4000, mk(64'h4000, 0, 0, 0, 5'd1, AluAdd, 1'b0), 1, st);
        repeat (2) tick();

        // Same-cycle writeback of x3 while add x13,x3,x0 is accepted
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 64'd5;
`ifdef DECODE_WB_BYPASS_EN
        issue(32'h000186B3, 64'h4004, mk(64'h4004, 64'd5, 0, 0, 5'd13, AluAdd, 1'b0), 1, st);
`else
        issue(32'h000186B3, 64'h4004, mk(64'h4004, 64'd0, 0, 0, 5'd13, AluAdd, 1'b0), 1, st);
`endif
        wb_en = 1'b0;
        // add x14,x3,x3 sees the written value in every build
        issue(32'h00318733, 64'h4008, mk(64'h4008, 64'd5, 64'd5, 0, 5'd14, AluAdd, 1'b0), 1, st);
        repeat (2) tick();

        // Reset mid-stall clears bundle and register file
        out_ready = 1'b0;
        issue(32'h00500493, 64'h5000, a_exp, 0, st);
        in_valid = 1'b1; in_ins = 32'hFFF02513;
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_imm", out_imm, 64'd0);
        check("midrst_out_dest_pc", {out_dest_reg, out_pc[31:0]}, 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        check("midrst_release_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        // add x18,x1,x2 after reset reads zeros
        issue(32'h00208933, 64'h5004, mk(64'h5004, 0, 0, 0, 5'd18, AluAdd, 1'b0), 1, st);

        repeat (5) tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the RV64 core: decodes one 32-bit instruction per cycle, reads a parametrised integer register file, builds the sign-extended immediate for every RV64I/M format, and presents a registered control/operand bundle to execute over a valid/ready handshake. It owns the register file write port driven by writeback, detects load-use hazards against the instruction it currently holds, and supports a pipeline flush from branch resolution.

## Interface
- BUS_DATA_WIDTH, 64, register and PC width
- NUM_REGS, 32, architectural integer registers; x0 hardwired to zero
- REG_ADDR_W, $clog2(NUM_REGS), register index width
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  BUS_DATA_WIDTH  PC of the instruction
- in_ins  in  32  instruction word
- flush  in  1  kill held and incoming instruction
- wb_en  in  1  register file write enable
- wb_rd  in  REG_ADDR_W  write index
- wb_data  in  BUS_DATA_WIDTH  write data
- out_valid  out  1  bundle valid for execute
- out_ready  in  1  execute accepts the bundle
- out_pc, out_read_data1, out_read_data2, out_imm  out  BUS_DATA_WIDTH  PC, rs1 value, rs2 value, immediate
- out_dest_reg  out  REG_ADDR_W  rd (0 when no write-back)
- out_alu_control  out  6  ALU operation code (package enum)
- out_alu_src  out  1  1 = immediate operand B
- out_branch, out_jump  out  1  conditional branch / JAL-JALR
- out_branch_type  out  3  funct3 of the branch
- out_mem_read, out_mem_write, out_reg_write, out_mem_or_reg  out  1  memory and write-back controls
- out_mem_size  out  3  funct3 of load/store (width + unsigned)
- out_illegal  out  1  unsupported opcode/funct combination

## Operation
- Decoded opcodes: OP-IMM, OP, OP-IMM-32, OP-32, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR; anything else sets out_illegal with reg_write, mem_read, mem_write, branch, jump all 0.
- Immediates: I = sext(ins[31:20]); S = sext({ins[31:25],ins[11:7]}); B = sext({ins[31],ins[7],ins[30:25],ins[11:8],1'b0}); U = sext({ins[31:12],12'b0}); J = sext({ins[31],ins[19:12],ins[20],ins[30:21],1'b0}). Shift-immediates use ins[25:20] (ins[24:20] for *W).
- Register read of index 0 returns 0; writes with wb_rd = 0 are discarded. out_dest_reg forced to 0 when reg_write = 0.
- Branches: out_alu_control = SUB, operands rs1/rs2, out_imm = B. LUI: operand A forced 0. AUIPC/JAL/JALR carry out_pc for execute's link/target adder.
- Hazard: hazard = out_valid & out_mem_read & out_dest_reg != 0 & (out_dest_reg == rs1 used | out_dest_reg == rs2 used). Source "used" per format (U/J use none; I/load use rs1 only).
- advance = !out_valid | out_ready. in_ready = advance & !hazard & !flush.
- On advance: if in_valid & in_ready, load bundle, out_valid = 1; else out_valid = 0 (bubble).
- flush (highest priority): next cycle out_valid = 0; in_valid ignored that cycle.

## Timing
- Decode latency 1 cycle: instruction accepted at edge N is on outputs after edge N; held stable while out_valid & !out_ready.
- Load-use: dependent instruction stalls exactly one cycle when execute accepts the load that same cycle.
- Register file write occurs at rising edge; read is of the array value at the accepting edge (see macro for same-cycle bypass).
- Reset (any time, including mid-stall): out_valid = 0, all out_* data/control = 0, all registers = 0; in_ready rises combinationally once reset_n deasserts.

## Configuration
- DECODE_WB_BYPASS_EN defined: when wb_en & wb_rd != 0 & wb_rd matches rs1/rs2 in the accepting cycle, wb_data is captured instead of the stale array value.
- Undefined: no bypass; writeback must occur at least one cycle before the read, and the hazard unit upstream accounts for it.

## Structure
- riscv_pkg: opcode constants, alu_op_e (6-bit codes for ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, *W variants, M-extension ops), imm_fmt_e.
- One sub-module: regfile (NUM_REGS x BUS_DATA_WIDTH, two async read ports, one write port, optional bypass).

## Test plan
- addi x5,x0,-1 (0xFFF00293) -> out_imm = 0xFFFF_FFFF_FFFF_FFFF, alu_src = 1, reg_write = 1, dest = 5, ADD.
- wb x7=0x1234 then beq x7,x7,-8 -> read_data1 = read_data2 = 0x1234, branch = 1, out_imm = -8, branch_type = 0.
- ld x6,0(x1) followed by add x8,x6,x2, out_ready=1 -> one bubble (in_ready=0 one cycle), add issues next.
- out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, no instruction lost.
- flush with valid held bundle -> out_valid=0 next cycle; instruction on in_ins that cycle not issued.
- wb_en to x0 with 0xDEAD, then add x1,x0,x0 -> read_data1 = 0; with DECODE_WB_BYPASS_EN, same-cycle wb x3=5 and read x3 -> 5.
